// File: rtl/display_scan6.sv
// display_scan6: time-multiplexed driver for six 7-segment digits.
// One shared segment bus, six active-low digit enables, a blanking gap at
// the start of every slot, per-digit blinking and a global display enable.
module display_scan6 #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_HZ     = 2,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] s_lsd,
    input  logic [6:0] s_msd,
    input  logic [6:0] m_lsd,
    input  logic [6:0] m_msd,
    input  logic [6:0] h_lsd,
    input  logic [6:0] h_msd,
    input  logic       display_en,
    input  logic [5:0] blink_mask,
    output logic [6:0] seg,
    output logic [5:0] dig_n,
    output logic [2:0] digit_idx,
    output logic       slot_start
);

    localparam int DIV  = CLK_HZ / SCAN_HZ;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [6:0]    SEG_BLANK  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [5:0]    DIG_OFF    = 6'h3F;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [BW-1:0] HALF_LAST  = BW'(HALF - 1);

    // Refuse to elaborate with a slot too short for its blanking gap or a
    // blink rate the clock cannot resolve.
    if (DIV <= BLANK_CYCLES + 1) begin : g_bad_div
        $error("display_scan6: CLK_HZ/SCAN_HZ must exceed BLANK_CYCLES+1");
    end
    if (CLK_HZ < 2 * BLINK_HZ) begin : g_bad_blink
        $error("display_scan6: CLK_HZ must be at least 2*BLINK_HZ");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("display_scan6: BLANK_CYCLES must be at least 1");
    end

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_digit_idx;
    logic [6:0]    r_hold;
    logic [6:0]    r_seg;
    logic [5:0]    r_dig_n;
    logic          r_slot_start;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;

    logic [6:0]    w_sel_code;
    logic [5:0]    w_sel_dig_n;
    logic          w_sel_mask;
    logic          w_visible;

    // Decode the current scan index into its input code, digit enable and blink bit.
    always_comb begin
        w_sel_code  = SEG_BLANK;
        w_sel_dig_n = DIG_OFF;
        w_sel_mask  = 1'b0;
        case (r_digit_idx)
            3'd0: begin w_sel_code = s_lsd; w_sel_dig_n = 6'b111110; w_sel_mask = blink_mask[0]; end
            3'd1: begin w_sel_code = s_msd; w_sel_dig_n = 6'b111101; w_sel_mask = blink_mask[1]; end
            3'd2: begin w_sel_code = m_lsd; w_sel_dig_n = 6'b111011; w_sel_mask = blink_mask[2]; end
            3'd3: begin w_sel_code = m_msd; w_sel_dig_n = 6'b110111; w_sel_mask = blink_mask[3]; end
            3'd4: begin w_sel_code = h_lsd; w_sel_dig_n = 6'b101111; w_sel_mask = blink_mask[4]; end
            3'd5: begin w_sel_code = h_msd; w_sel_dig_n = 6'b011111; w_sel_mask = blink_mask[5]; end
            default: begin
                w_sel_code  = SEG_BLANK;
                w_sel_dig_n = DIG_OFF;
                w_sel_mask  = 1'b0;
            end
        endcase
        // A masked digit goes dark while the blink phase is off.
        w_visible = display_en & ~(w_sel_mask & ~r_blink_on);
    end

    // Scan FSM: slot counter, digit index, code capture and registered pin outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_BLANK;
            r_cnt        <= {CW{1'b0}};
            r_digit_idx  <= 3'd0;
            r_hold       <= SEG_BLANK;
            r_seg        <= SEG_BLANK;
            r_dig_n      <= DIG_OFF;
            r_slot_start <= 1'b0;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt       <= {CW{1'b0}};
                r_state     <= ST_BLANK;
                r_digit_idx <= (r_digit_idx == 3'd5) ? 3'd0 : r_digit_idx + 3'd1;
            end else begin
                r_cnt       <= r_cnt + CW'(1);
                r_digit_idx <= r_digit_idx;
                if ((r_state == ST_BLANK) && (r_cnt == BLANK_LAST)) begin
                    r_state <= ST_SHOW;
                end else begin
                    r_state <= r_state;
                end
            end

            // The code is frozen for the whole slot so mid-slot edits cannot tear the digit.
            if (r_cnt == {CW{1'b0}}) begin
                r_hold <= w_sel_code;
            end else begin
                r_hold <= r_hold;
            end

            r_slot_start <= (r_cnt == {CW{1'b0}});

            case (r_state)
                ST_BLANK: begin
                    r_seg   <= SEG_BLANK;
                    r_dig_n <= DIG_OFF;
                end
                ST_SHOW: begin
                    if (w_visible) begin
                        r_seg   <= r_hold;
                        r_dig_n <= w_sel_dig_n;
                    end else begin
                        r_seg   <= SEG_BLANK;
                        r_dig_n <= DIG_OFF;
                    end
                end
                default: begin
                    r_seg   <= SEG_BLANK;
                    r_dig_n <= DIG_OFF;
                end
            endcase
        end
    end

    // Free-running blink timer; blink_on flips every half-period and starts visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= {BW{1'b0}};
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == HALF_LAST) begin
            r_blink_cnt <= {BW{1'b0}};
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
            r_blink_on  <= r_blink_on;
        end
    end

    assign seg        = r_seg;
    assign dig_n      = r_dig_n;
    assign digit_idx  = r_digit_idx;
    assign slot_start = r_slot_start;

endmodule

// File: tb/tb_display_scan6.sv
// Scoreboard bench for display_scan6 (DIV=12, 2 blank clocks, blink half-period 60).
module tb_display_scan6;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] codes [6];
    logic       display_en;
    logic [5:0] blink_mask;
    logic [6:0] seg;
    logic [5:0] dig_n;
    logic [2:0] digit_idx;
    logic       slot_start;

    typedef struct {
        int          idx;
        logic [6:0]  code;
        logic [11:0] vis;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    always #5 clock = ~clock;

    display_scan6 #(
        .CLK_HZ(1200),
        .SCAN_HZ(100),
        .BLANK_CYCLES(2),
        .BLINK_HZ(10),
        .SEG_ACT_LOW(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .s_lsd(codes[0]),
        .s_msd(codes[1]),
        .m_lsd(codes[2]),
        .m_msd(codes[3]),
        .h_lsd(codes[4]),
        .h_msd(codes[5]),
        .display_en(display_en),
        .blink_mask(blink_mask),
        .seg(seg),
        .dig_n(dig_n),
        .digit_idx(digit_idx),
        .slot_start(slot_start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_dig_n"}, 32'(dig_n), 32'h3F);
        chk({tag, "_slot_start"}, 32'(slot_start), 32'h0);
        chk({tag, "_digit_idx"}, 32'(digit_idx), 32'h0);
    endtask

    // Issue slots from a reset release; slot j covers output samples after edges 12j+1..12j+12.
    task automatic run_phase(input int phase, input int nslots, input int rst_slot);
        for (int j = 0; j < nslots; j++) begin
            exp_t e;
            int   idx;
            logic blink_on;
            if (phase == 0) begin
                blink_mask = (j >= 12 && j < 30) ? 6'b110000 : 6'b000000;
                if (j == 34) display_en = 1'b1;
            end
            idx      = j % 6;
            blink_on = ((j / 5) % 2) == 0;
            e.idx    = idx;
            e.code   = codes[idx];
            e.vis    = 12'h000;
            for (int k = 2; k < 12; k++) begin
                e.vis[k] = display_en && !(blink_mask[idx] && !blink_on);
            end
            if (phase == 0 && j == 31) e.vis = e.vis & 12'h03F;
            q.push_back(e);
            pushed++;
            for (int c = 1; c <= 12; c++) begin
                @(posedge clock);
                #1;
                if (phase == 0 && j == 8 && c == 5) codes[2] = 7'h02;
                if (phase == 0 && j == 31 && c == 6) display_en = 1'b0;
                if (j == rst_slot && c == 5) begin
                    reset = 1'b1;
                    #1;
                    chk_reset_outputs("midslot_reset");
                    repeat (3) @(posedge clock);
                    #1;
                    reset = 1'b0;
                    return;
                end
            end
        end
    endtask

    // Monitor: per-clock invariants plus a popped expectation for every slot_start.
    initial begin
        exp_t cur;
        int   k;
        bit   has_cur;
        has_cur = 1'b0;
        k       = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                has_cur = 1'b0;
            end else begin
                chk("one_digit_low", 32'($countones(~dig_n) <= 1), 32'h1);
                chk("idx_range", 32'(digit_idx <= 3'd5), 32'h1);
                if (slot_start) begin
                    chk("slot_length", 32'(has_cur), 32'h0);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: slot_start with no expectation (t=%0t)", $time);
                        has_cur = 1'b0;
                    end else begin
                        cur = q.pop_front();
                        popped++;
                        has_cur = 1'b1;
                        k = 0;
                        chk("slot_idx", 32'(digit_idx), 32'(cur.idx));
                    end
                end
                if (has_cur) begin
                    if (cur.vis[k]) begin
                        chk("dig_n", 32'(dig_n), 32'(~(6'b000001 << cur.idx) & 6'h3F));
                        chk("seg", 32'(seg), 32'(cur.code));
                    end else begin
                        chk("dig_n_dark", 32'(dig_n), 32'h3F);
                        chk("seg_dark", 32'(seg), 32'h7F);
                    end
                    k++;
                    if (k == 12) has_cur = 1'b0;
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        display_en = 1'b1;
        blink_mask = 6'b000000;
        codes[0]   = 7'h40;
        codes[1]   = 7'h79;
        codes[2]   = 7'h24;
        codes[3]   = 7'h30;
        codes[4]   = 7'h19;
        codes[5]   = 7'h12;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        // Phase 0: plain scan, mid-slot code edit, blinking, display_en drop, reset in slot 39 (digit 3).
        run_phase(0, 40, 39);
        // Phase 1: restart after reset, seven slots to cover the 5->0 wrap.
        run_phase(1, 7, -1);
        @(negedge clock);
        chk("sb_drain", 32'(popped), 32'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
